// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
//   XLEN_DEF, NREGS_DEF : default data width and register count
//   field_lsb()         : start bit of field idx in a flattened bus of
//                         equal-width fields, used as bus[field_lsb(i, w) +: w]
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard with a registered popcount.
//   clk, reset  : clock, asynchronous active-high reset
//   clr_vec     : registers written back this cycle (clear busy)
//   set_vec     : register issued this cycle (set busy, wins over clear)
//   busy        : registered busy bit per register
//   busy_count  : number of set busy bits, updated on the same edge
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int CW    = $clog2(NREGS_DEF) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREGS-1:0] clr_vec,
    input  logic [NREGS-1:0] set_vec,
    output logic [NREGS-1:0] busy,
    output logic [CW-1:0]    busy_count
);

    logic [NREGS-1:0] busy_next;
    logic [CW-1:0]    count_next;

    // Counting the next-state vector keeps busy_count aligned with busy
    // after every edge, with no extra cycle of lag.
    always_comb begin
        busy_next  = (busy & ~clr_vec) | set_vec;
        count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            count_next = count_next + CW'(busy_next[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port integer register file with busy scoreboard.
//   clk, reset : clock, asynchronous active-high reset
//   rd_addr    : NRD read addresses, port k at [k*AW +: AW]
//   rd_data    : NRD combinational read results
//   rd_busy    : registered busy bit of each addressed register
//   wr_en      : NWR write enables
//   wr_addr    : NWR write addresses
//   wr_data    : NWR write data words
//   iss_valid  : an instruction with a destination issues this cycle
//   iss_rd     : destination register of the issuing instruction
//   busy_count : number of busy registers
//   all_idle   : no register is busy
module register_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic [AW:0]         busy_count,
    output logic                all_idle
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NWR-1:0]   wr_take;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] busy;

    // A write is stored unless it targets the hard-wired zero register.
    always_comb begin
        wr_take = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_take[j] = wr_en[j] &&
                !((ZERO_REG != 0) && (wr_addr[field_lsb(j, AW) +: AW] == '0));
        end
    end

    // Ports are applied in ascending order so the highest-index port's
    // assignment is the one that lands when addresses collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_take[j]) begin
                    regs[wr_addr[field_lsb(j, AW) +: AW]] <= wr_data[field_lsb(j, XLEN) +: XLEN];
                end
            end
        end
    end

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                clr_vec[wr_addr[field_lsb(j, AW) +: AW]] = 1'b1;
            end
        end
        if (iss_valid && !((ZERO_REG != 0) && (iss_rd == '0))) begin
            set_vec[iss_rd] = 1'b1;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .CW    (AW + 1)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .clr_vec    (clr_vec),
        .set_vec    (set_vec),
        .busy       (busy),
        .busy_count (busy_count)
    );

    assign all_idle = (busy_count == '0);

    // Read mux. Reset forces zero so a write pending during reset is never
    // visible through the bypass path.
    always_comb begin
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] word;
        logic            zero_hit;
        rd_data  = '0;
        rd_busy  = '0;
        addr     = '0;
        word     = '0;
        zero_hit = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            addr     = rd_addr[field_lsb(k, AW) +: AW];
            zero_hit = (ZERO_REG != 0) && (addr == '0);
            word     = regs[addr];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && (wr_addr[field_lsb(j, AW) +: AW] == addr)) begin
                        word = wr_data[field_lsb(j, XLEN) +: XLEN];
                    end
                end
            end
            if (zero_hit || reset) begin
                word = '0;
            end
            rd_data[field_lsb(k, XLEN) +: XLEN] = word;
            rd_busy[k] = busy[addr] && !zero_hit;
        end
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port integer register file for the pipelined core, replacing the fixed 2R1W file. It provides NRD combinational read ports and NWR write ports, with optional same-cycle write-to-read bypass. A per-register busy scoreboard is set at issue and cleared at writeback, so the hazard unit can stall on RAW dependences. It sits between decode (read/issue) and writeback.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers; power of two, at least 2
NRD, 2, number of read ports
NWR, 2, number of write ports
BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns the stored value
ZERO_REG, 1, 1 = register 0 is hard-wired to zero and is never marked busy
(localparam AW = $clog2(NREGS))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NRD*XLEN  read data per port
rd_busy  out  NRD  busy bit of each addressed register
wr_en  in  NWR  write enables
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
iss_valid  in  1  an instruction with a destination register issues this cycle
iss_rd  in  AW  destination register of the issuing instruction
busy_count  out  AW+1  number of registers currently busy
all_idle  out  1  1 when busy_count is 0

Behaviour:
- Reset is asynchronous and active-high; clock is clk. Reset clears all registers to 0 and all busy bits to 0. During and after reset: rd_data = 0 for every address, rd_busy = 0, busy_count = 0, all_idle = 1. A reset asserted mid-operation discards every pending write and issue in that cycle.
- Reads are combinational, with zero latency.
  - ZERO_REG=1 and address 0: rd_data = 0 and rd_busy = 0.
  - BYPASS=1 and some wr_en[j] is set with wr_addr[j] equal to the read address (and that address is not a masked register 0): rd_data = the winning wr_data, chosen by the same priority as writes below.
  - Otherwise: rd_data = the stored value.
- Writes occur on the rising clock edge.
  - Each port j with wr_en[j]=1 writes wr_data[j] to wr_addr[j].
  - If ZERO_REG=1, writes to register 0 are dropped.
  - If several ports target the same address, the highest-index port wins.
- Scoreboard, updated on the rising clock edge:
  - Each write with wr_en[j]=1 clears busy[wr_addr[j]].
  - iss_valid=1 sets busy[iss_rd]. Set wins over a clear to the same register in the same cycle, because the newer producer is outstanding.
  - If ZERO_REG=1, setting busy[0] is ignored.
  - Issuing to a register that is already busy leaves it busy. There is no counting; only one outstanding producer is tracked per register.
  - A write to a register that is not busy is legal and leaves busy = 0.
- rd_busy reflects the registered busy state. A writeback in the current cycle does not clear it combinationally; the hazard unit uses the bypassed rd_data together with rd_busy.
- busy_count is a registered popcount, updated in the same edge as the busy bits, so it equals the number of set busy bits after that edge. all_idle = (busy_count == 0).
- Out-of-range addresses cannot occur because NREGS is a power of two.

Decomposition:
- Shared package (e.g. rf_pkg): default XLEN and NREGS constants and a helper function that slices a flattened port bus.
- Sub-module rf_scoreboard: busy bit vector plus the busy_count register, with inputs clr_vec and set_vec computed in the parent.
- The storage array and the read/bypass mux stay in register_file_mp.

Test Plan:
1. Reset mid-operation: write 0xDEADBEEF to register 5, then assert reset -> rd_data for address 5 = 0, busy_count = 0, all_idle = 1 immediately (asynchronous).
2. Dual write, same address, BYPASS=1: wr_en = 2'b11, both addresses = 7, data 0x11 on port 0 and 0x22 on port 1; read address 7 in the same cycle -> rd_data = 0x22 both combinationally and after the edge.
3. Zero register: write 0x1234 to register 0 and issue to register 0 -> rd_data = 0, rd_busy = 0, busy_count unchanged.
4. Scoreboard lifecycle:
   - Issue to register 3 -> rd_busy = 1 next cycle, busy_count = 1.
   - Write register 3 -> busy cleared next cycle, all_idle = 1.
5. Simultaneous set and clear: register 9 is busy; in one cycle, write register 9 with 0xAA and issue to register 9 -> busy stays 1, register 9 holds 0xAA, busy_count unchanged.
6. Bypass off: BYPASS=0, register 4 holds 0x5; write 0x6 to register 4 -> read returns 0x5 during the write cycle and 0x6 on the next cycle. Sweep all NRD ports with distinct addresses to check there is no crosstalk between ports.
